// File: rtl/fractcam_bank.sv
// rtl/fractcam_bank.sv - FracTCAM search bank with serial group write sequencer
//
// Ternary CAM of 8*ROWS entries by 5*COLS key bits. Each 5-bit key column of
// each 8-entry group is held as a 32x8 match table (key value x rule). Search
// is a combinational lookup per column, ANDed across columns.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_addr       group base address; bits [AW-1:3] select the group
//   wr_data       8 rule values, rule r in [r*KW +: KW]
//   wr_keep       8 care masks, 1 = bit must match
//   wr_valid      write request, accepted when wr_ready is high
//   wr_ready      high while idle and able to accept a group write
//   search_key    lookup key
//   match_valid   high when match_line reflects search_key
//   match_line    one match bit per entry
module fractcam_bank #(
  parameter int COLS = 2,
  parameter int ROWS = 2,
  parameter int AW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          wr_addr,
  input  logic [8*5*COLS-1:0]    wr_data,
  input  logic [8*5*COLS-1:0]    wr_keep,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [5*COLS-1:0]      search_key,
  output logic                   match_valid,
  output logic [8*ROWS-1:0]      match_line
);

  localparam int KW = 5 * COLS;
  localparam int D  = 8 * ROWS;

  generate
    if (AW < $clog2(D)) begin : g_aw_check
      $error("fractcam_bank: AW is narrower than clog2(8*ROWS)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [AW-1:0]     grp_q, grp_d;
  logic [8*KW-1:0]   data_q, data_d;
  logic [8*KW-1:0]   keep_q, keep_d;

  // Per (column, rule) 32-deep staging shift registers.
  logic [31:0]       sr_q [COLS][8];
  logic [31:0]       sr_d [COLS][8];

  // Match tables: t_q[c][g][v][r].
  logic [7:0]        t_q  [COLS][ROWS][32];
  logic [7:0]        t_d  [COLS][ROWS][32];

  logic [7:0]        stage_bit [COLS];
  logic              accept;
  logic [KW-1:0]     lookup_key;

  assign accept      = wr_valid && ready_q;
  assign wr_ready    = ready_q;
  assign match_valid = ready_q;

  // Table bit for key value cnt: 1 when every cared-for bit of the rule
  // column equals the corresponding bit of cnt.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < 8; r++) begin
        stage_bit[c][r] = ~|(keep_q[r*KW + 5*c +: 5] & (data_q[r*KW + 5*c +: 5] ^ cnt_q));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    data_d  = data_q;
    keep_d  = keep_q;
    sr_d    = sr_q;
    t_d     = t_q;
    // wr_ready is registered so it rises one cycle after the last table
    // write; the cycle following COMMIT is idle but not yet accepting.
    ready_d = (state_q == IDLE) && !accept;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STAGE;
          cnt_d   = 5'd0;
          grp_d   = wr_addr >> 3;
          data_d  = wr_data;
          keep_d  = wr_keep;
        end
      end
      STAGE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cnt_d = cnt_q + 5'd1;
        // After 32 shifts the oldest bit is the one staged for this cnt.
        for (int c = 0; c < COLS; c++) begin
          for (int g = 0; g < ROWS; g++) begin
            if (grp_q == AW'(g)) begin
              for (int r = 0; r < 8; r++) begin
                t_d[c][g][cnt_q][r] = sr_q[c][r][31];
              end
            end
          end
        end
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shift continuously while busy; during COMMIT the input is unused.
    if (state_q != IDLE) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < 8; r++) begin
          sr_d[c][r] = {sr_q[c][r][30:0], stage_bit[c][r]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      grp_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      sr_q    <= '{default: '0};
      t_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      sr_q    <= sr_d;
      t_q     <= t_d;
    end
  end

  // While busy the lookup runs on the counter key; output is don't-care then.
  assign lookup_key = (state_q == IDLE) ? search_key : {COLS{cnt_q}};

  always_comb begin
    logic hit;
    hit        = 1'b1;
    match_line = '0;
    for (int g = 0; g < ROWS; g++) begin
      for (int r = 0; r < 8; r++) begin
        hit = 1'b1;
        for (int c = 0; c < COLS; c++) begin
          hit = hit & t_q[c][g][lookup_key[5*c +: 5]][r];
        end
        match_line[g*8 + r] = hit;
      end
    end
  end

endmodule

// File: tb/tb_fractcam_bank.sv
// tb/tb_fractcam_bank.sv - self-checking bench for fractcam_bank
module tb_fractcam_bank;

  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int AW   = 4;
  localparam int KW   = 5 * COLS;
  localparam int D    = 8 * ROWS;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     wr_addr;
  logic [8*KW-1:0]   wr_data;
  logic [8*KW-1:0]   wr_keep;
  logic              wr_valid;
  logic              wr_ready;
  logic [KW-1:0]     search_key;
  logic              match_valid;
  logic [D-1:0]      match_line;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one (data, keep) rule per entry plus a written flag.
  logic [KW-1:0] m_data [D];
  logic [KW-1:0] m_keep [D];
  bit            m_wr   [D];

  fractcam_bank #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_keep     (wr_keep),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .search_key  (search_key),
    .match_valid (match_valid),
    .match_line  (match_line)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [D-1:0] model_match(input logic [KW-1:0] key);
    logic [D-1:0] m;
    m = '0;
    for (int e = 0; e < D; e++)
      m[e] = m_wr[e] && (((key ^ m_data[e]) & m_keep[e]) == '0);
    return m;
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < D; e++) begin
      m_wr[e] = 1'b0; m_data[e] = '0; m_keep[e] = '0;
    end
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [8*KW-1:0] d,
                                      input logic [8*KW-1:0] k);
    int g;
    g = int'(a) / 8;
    if (g < ROWS) begin
      for (int r = 0; r < 8; r++) begin
        m_wr[g*8 + r]   = 1'b1;
        m_data[g*8 + r] = d[r*KW +: KW];
        m_keep[g*8 + r] = k[r*KW +: KW];
      end
    end
  endfunction

  // Half uniform keys, half keys built to hit a chosen rule.
  function automatic logic [KW-1:0] pick_key();
    int e;
    e = $urandom_range(D-1);
    if ($urandom_range(1) == 0) return KW'($urandom);
    return (m_data[e] & m_keep[e]) | (KW'($urandom) & ~m_keep[e]);
  endfunction

  function automatic logic [8*KW-1:0] rand_bus();
    logic [8*KW-1:0] b;
    for (int r = 0; r < 8; r++) b[r*KW +: KW] = KW'($urandom);
    return b;
  endfunction

  task automatic drive_write(input logic [AW-1:0] a, input logic [8*KW-1:0] d,
                             input logic [8*KW-1:0] k);
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_keep = k; wr_valid = 1'b1;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (wr_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_keep = '0; search_key = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    n_tests++;
    if (match_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid: got %b want 1", match_valid); end
    search_key = 10'h000; #1;
    n_tests++;
    if (match_line !== 16'h0000) begin n_fail++; $display("FAIL reset_key000: got %h want 0000", match_line); end
    search_key = 10'h3FF; #1;
    n_tests++;
    if (match_line !== 16'h0000) begin n_fail++; $display("FAIL reset_key3ff: got %h want 0000", match_line); end
  endtask

  task automatic test_single_write();
    logic [8*KW-1:0] d, k;
    int low_err;
    for (int r = 0; r < 8; r++) begin
      d[r*KW +: KW] = (r == 0) ? 10'h155 : 10'h000;
      k[r*KW +: KW] = 10'h3FF;
    end
    drive_write(4'd0, d, k);
    low_err = 0;
    for (int c = 0; c <= 64; c++) begin
      @(negedge clk);
      if (wr_ready !== 1'b0) low_err++;
    end
    n_tests++;
    if (low_err != 0) begin n_fail++; $display("FAIL busy_low: %0d cycles with wr_ready high, want 0", low_err); end
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_at_65: got %b want 1", wr_ready); end
    model_write(4'd0, d, k);
    search_key = 10'h155; #1;
    n_tests++;
    if (match_line !== 16'h0001) begin n_fail++; $display("FAIL w1_key155: got %h want 0001", match_line); end
    search_key = 10'h154; #1;
    n_tests++;
    if (match_line !== 16'h0000) begin n_fail++; $display("FAIL w1_key154: got %h want 0000", match_line); end
    search_key = 10'h000; #1;
    n_tests++;
    if (match_line !== 16'h00FE) begin n_fail++; $display("FAIL w1_key000: got %h want 00fe", match_line); end
  endtask

  task automatic test_dont_care();
    logic [8*KW-1:0] d, k;
    bit ok;
    for (int r = 0; r < 8; r++) begin
      d[r*KW +: KW] = (r == 2) ? 10'h0AB : 10'h3FF;
      k[r*KW +: KW] = (r == 2) ? 10'h0F0 : 10'h3FF;
    end
    drive_write(4'd8, d, k);
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dc_timeout: wr_ready got 0 want 1"); end
    model_write(4'd8, d, k);
    @(negedge clk);
    search_key = 10'h3AF; #1;
    n_tests++;
    if (match_line[10] !== 1'b1) begin n_fail++; $display("FAIL dc_key3af: bit10 got %b want 1", match_line[10]); end
    search_key = 10'h08B; #1;
    n_tests++;
    if (match_line[10] !== 1'b0) begin n_fail++; $display("FAIL dc_key08b: bit10 got %b want 0", match_line[10]); end
    search_key = 10'h3FF; #1;
    n_tests++;
    if (match_line !== 16'hFB00) begin n_fail++; $display("FAIL dc_key3ff: got %h want fb00", match_line); end
    search_key = 10'h000; #1;
    n_tests++;
    if (match_line !== 16'h00FE) begin n_fail++; $display("FAIL dc_group0_key000: got %h want 00fe", match_line); end
    search_key = 10'h155; #1;
    n_tests++;
    if (match_line !== 16'h0001) begin n_fail++; $display("FAIL dc_group0_key155: got %h want 0001", match_line); end
    for (int i = 0; i < 24; i++) begin
      search_key = pick_key(); #1;
      n_tests++;
      if (match_line !== model_match(search_key)) begin
        n_fail++; $display("FAIL dc_rand key=%h: got %h want %h", search_key, match_line, model_match(search_key));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8*KW-1:0] da, ka, db, kb, dj;
    int n, seen;
    bit ok, done;
    da = rand_bus(); ka = rand_bus() | rand_bus();
    db = rand_bus(); kb = rand_bus() | rand_bus();
    wait_ready(ok);
    @(negedge clk);
    wr_addr = 4'd0; wr_data = da; wr_keep = ka; wr_valid = 1'b1;
    @(posedge clk);
    #1 wr_addr = 4'd13; wr_data = db; wr_keep = kb;
    n = 0; seen = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (wr_ready === 1'b1) begin
        seen = n;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        done = 1'b1;
      end
    end
    wr_valid = 1'b0;
    n_tests++;
    if (seen != 66) begin n_fail++; $display("FAIL b2b_ready_cycle: got %0d want 66", seen); end
    n_tests++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: wr_ready got %b want 0", wr_ready); end
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: wr_ready got 0 want 1"); end
    model_write(4'd0, da, ka);
    model_write(4'd13, db, kb);
    // Spurious pulses while busy must neither be captured nor corrupt T.
    da = rand_bus(); ka = rand_bus() | rand_bus();
    drive_write(4'd0, da, ka);
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (wr_ready === 1'b0 && $urandom_range(2) == 0) begin
        dj = rand_bus();
        wr_addr = AW'($urandom); wr_data = dj; wr_keep = dj; wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
      end
    end
    n_tests++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL spur_timeout: wr_ready got 0 want 1"); end
    model_write(4'd0, da, ka);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      search_key = pick_key(); #1;
      n_tests++;
      if (match_line !== model_match(search_key)) begin
        n_fail++; $display("FAIL b2b_rand key=%h: got %h want %h", search_key, match_line, model_match(search_key));
      end
    end
  endtask

  task automatic test_overwrite();
    logic [8*KW-1:0] d, k;
    bit ok;
    d = rand_bus(); k = '0;
    drive_write(4'd3, d, k);
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ow_timeout: wr_ready got 0 want 1"); end
    model_write(4'd3, d, k);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      search_key = KW'($urandom); #1;
      n_tests++;
      if (match_line[7:0] !== 8'hFF) begin n_fail++; $display("FAIL ow_group0 key=%h: got %h want ff", search_key, match_line[7:0]); end
      n_tests++;
      if (match_line !== model_match(search_key)) begin
        n_fail++; $display("FAIL ow_full key=%h: got %h want %h", search_key, match_line, model_match(search_key));
      end
    end
  endtask

  task automatic test_random_writes();
    logic [8*KW-1:0] d, k;
    logic [AW-1:0] a;
    bit ok;
    for (int w = 0; w < 4; w++) begin
      a = AW'($urandom); d = rand_bus(); k = rand_bus() | rand_bus();
      drive_write(a, d, k);
      wait_ready(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rnd_timeout: wr_ready got 0 want 1"); end
      model_write(a, d, k);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        search_key = pick_key(); #1;
        n_tests++;
        if (match_line !== model_match(search_key)) begin
          n_fail++; $display("FAIL rnd key=%h: got %h want %h", search_key, match_line, model_match(search_key));
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [8*KW-1:0] d, k;
    bit ok;
    wait_ready(ok);
    d = rand_bus(); k = rand_bus();
    drive_write(4'd8, d, k);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", wr_ready); end
    n_tests++;
    if (match_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", match_valid); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      search_key = (i == 0) ? 10'h000 : (i == 1) ? 10'h3FF : KW'($urandom); #1;
      n_tests++;
      if (match_line !== 16'h0000) begin n_fail++; $display("FAIL rstmid_clear key=%h: got %h want 0000", search_key, match_line); end
    end
    d = rand_bus(); k = rand_bus() | rand_bus();
    drive_write(4'd8, d, k);
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_rewrite_timeout: wr_ready got 0 want 1"); end
    model_write(4'd8, d, k);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      search_key = pick_key(); #1;
      n_tests++;
      if (match_line !== model_match(search_key)) begin
        n_fail++; $display("FAIL rstmid_rewrite key=%h: got %h want %h", search_key, match_line, model_match(search_key));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dont_care();
    test_back_to_back();
    test_overwrite();
    test_random_writes();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fractcam_bank.md
Name: fractcam_bank

Overview:
- FracTCAM search bank: ternary CAM of 8*ROWS entries by 5*COLS key bits.
- Each 5-bit key column of each 8-entry group is stored as a 32x8 match table, one bit per (key value, entry), written serially over 64 cycles.
- Search is a combinational table lookup per column, ANDed across columns to give one match bit per entry.
- Sits below the packet-classification match stage; the upstream controller issues 8-rule group writes.

Parameters:
- COLS, 2: number of 5-bit key columns; key width KW = 5*COLS.
- ROWS, 2: number of 8-entry groups; depth D = 8*ROWS.
- AW, 4: write address width; must be >= clog2(D). Elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wr_addr  in  AW  entry address of group base; bits [AW-1:3] select the group, bits [2:0] are ignored.
- wr_data  in  8*KW  rule values; rule r in bits [r*KW +: KW], entry = group*8+r.
- wr_keep  in  8*KW  care mask; 1 = bit must match, 0 = don't care.
- wr_valid  in  1  write request.
- wr_ready  out  1  high when idle.
- search_key  in  KW  lookup key.
- match_valid  out  1  high when match_line reflects search_key.
- match_line  out  D  bit e = 1 when entry e matches search_key.

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Storage: T[c][g][v][r] for column c, group g, key value v in 0..31, rule r in 0..7.
- Lookup (combinational): match_line[g*8+r] = AND over c of T[c][g][search_key[5c+4:5c]][r].
- match_valid = wr_ready. match_line is don't-care while busy; it is computed from the internal counter key during that time.
- Reset: all T bits cleared to 0, so no entry matches. Sequencer returns to idle, wr_ready=1, match_valid=1, counter=0. An in-progress write is abandoned.
- Handshake: on a clk edge with wr_valid && wr_ready, capture wr_addr, wr_data and wr_keep into registers. wr_ready drops the next cycle. Inputs may change after acceptance.
- State machine IDLE -> STAGE -> COMMIT -> IDLE, with a 5-bit counter cnt.
- STAGE, 32 cycles, cnt = 0..31:
  - for each (c, r), compute bit = NOR(keep_c,r & (data_c,r ^ cnt)) over the 5 bits;
  - shift that bit into a 32-deep shift register SR[c][r].
- COMMIT, 32 cycles, cnt = 0..31:
  - write T[c][g][cnt][r] = SR[c][r] oldest bit, which is the bit computed for the same cnt in STAGE;
  - SR continues shifting, with don't-care input.
- IDLE is re-entered after the last COMMIT cycle: wr_ready=1 exactly 65 cycles after the acceptance edge.
- New group contents are visible on match_line from the first idle cycle.
- Other groups are never modified. Rewriting a group fully replaces its 8 rules; there is no partial update.
- wr_valid while busy is ignored (not captured, no effect).
- Reset is asynchronous: it takes effect immediately regardless of clk.
- No read-back port. Search works only while idle.

Test Plan:
- Reset, then apply search_key 0x000 and 0x3FF -> match_line = 0x0000, match_valid = 1.
- Write wr_addr=0 with rule0 data=0x155 keep=0x3FF and rules1-7 data=0 keep=0x3FF. Wait for wr_ready (65 cycles, check wr_ready=0 throughout). Then:
  - key 0x155 -> match_line = 0x0001;
  - key 0x154 -> 0x0000;
  - key 0x000 -> 0x00FE.
- Don't-care: write wr_addr=8 with rule2 data=0x0AB keep=0x0F0, others keep=0x3FF data=0x3FF. Then:
  - key 0x3AF -> bit10 = 1;
  - key 0x08B -> bit10 = 0;
  - key 0x3FF -> bits 8,9,11-15 = 1 and bit10 = 0;
  - group0 bits unchanged from the previous write.
- Back-to-back: hold wr_valid high for two requests. The second is accepted only on the cycle wr_ready returns. Spurious wr_valid pulses during busy do not alter T.
- Overwrite: rewrite group0 with all keep=0 -> every key gives match_line[7:0] = 0xFF.
- Reset mid-write: assert rst at cycle 40 of a write -> wr_ready = 1 immediately and match_line = 0 for all keys.
